// File: rtl/wb_ctrl_pkg.sv
// Shared constants and types for the integer register-file write-back controller.
package wb_ctrl_pkg;

  localparam int WB_XLEN       = 64;
  localparam int WB_NREG       = 32;
  localparam int WB_IDX_W      = $clog2(WB_NREG);
  localparam int WB_STARVE_MAX = 4;

  localparam logic [WB_IDX_W-1:0] X0_IDX = '0;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_MDU = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_ctrl_scoreboard.sv
// Per-register busy scoreboard with two decode query ports.
// With WB_BYPASS_EN defined, a query matching the in-flight write reports a forward hit instead of busy.
module wb_scoreboard
  import wb_ctrl_pkg::*;
#(
  parameter int NREG  = WB_NREG,
  parameter int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [IDX_W-1:0] iss_rd,
  input  logic             wr_ena,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [IDX_W-1:0] rs1_index,
  input  logic [IDX_W-1:0] rs2_index,
`ifdef WB_BYPASS_EN
  output logic             rs1_fwd_hit,
  output logic             rs2_fwd_hit,
`endif
  output logic             rs1_busy,
  output logic             rs2_busy
);

  logic [NREG-1:1] busy_q, busy_d;
  logic [NREG-1:0] busy_vec;
  logic            rs1_sb, rs2_sb;

  // Set is applied after clear so a fresh producer outranks the retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (wr_ena && wr_index == IDX_W'(i))   busy_d[i] = 1'b0;
      if (iss_valid && iss_rd == IDX_W'(i)) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = {busy_q, 1'b0};
  assign rs1_sb   = busy_vec[rs1_index];
  assign rs2_sb   = busy_vec[rs2_index];

`ifdef WB_BYPASS_EN
  assign rs1_fwd_hit = wr_ena && (wr_index == rs1_index) && (rs1_index != X0_IDX);
  assign rs2_fwd_hit = wr_ena && (wr_index == rs2_index) && (rs2_index != X0_IDX);
  assign rs1_busy    = rs1_sb && !rs1_fwd_hit;
  assign rs2_busy    = rs2_sb && !rs2_fwd_hit;
`else
  assign rs1_busy    = rs1_sb;
  assign rs2_busy    = rs2_sb;
`endif

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: arbitrates ALU/LSU/MDU results onto the single regfile write port.
// Optional WB_BYPASS_EN adds operand forwarding from the write stage.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int XLEN       = WB_XLEN,
  parameter int NREG       = WB_NREG,
  parameter int STARVE_MAX = WB_STARVE_MAX,
  parameter int IDX_W      = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [IDX_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]  mdu_data,
  input  logic             iss_valid,
  input  logic [IDX_W-1:0] iss_rd,
  input  logic [IDX_W-1:0] rs1_index,
  input  logic [IDX_W-1:0] rs2_index,
  output logic             rs1_busy,
  output logic             rs2_busy,
`ifdef WB_BYPASS_EN
  output logic             rs1_fwd_hit,
  output logic             rs2_fwd_hit,
  output logic [XLEN-1:0]  rs1_fwd_data,
  output logic [XLEN-1:0]  rs2_fwd_data,
`endif
  output logic             rd_ena,
  output logic [IDX_W-1:0] rd_index,
  output logic [XLEN-1:0]  rd_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starve;
  logic             gnt_vld;
  wb_src_e          gnt_src;
  logic [IDX_W-1:0] sel_rd;
  logic [XLEN-1:0]  sel_data;

  logic             rd_ena_q, rd_ena_d;
  logic [IDX_W-1:0] rd_index_q, rd_index_d;
  logic [XLEN-1:0]  rd_data_q, rd_data_d;

  assign starve = (starve_q == CNT_W'(STARVE_MAX));

  // A starved MDU jumps the queue; otherwise fixed ALU > LSU > MDU.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_ALU;
    if (starve && mdu_valid) begin
      gnt_vld = 1'b1;
      gnt_src = SRC_MDU;
    end else if (alu_valid) begin
      gnt_vld = 1'b1;
      gnt_src = SRC_ALU;
    end else if (lsu_valid) begin
      gnt_vld = 1'b1;
      gnt_src = SRC_LSU;
    end else if (mdu_valid) begin
      gnt_vld = 1'b1;
      gnt_src = SRC_MDU;
    end
    if (rst) gnt_vld = 1'b0;
  end

  assign alu_ready = gnt_vld && (gnt_src == SRC_ALU);
  assign lsu_ready = gnt_vld && (gnt_src == SRC_LSU);
  assign mdu_ready = gnt_vld && (gnt_src == SRC_MDU);

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    case (gnt_src)
      SRC_LSU: begin sel_rd = lsu_rd; sel_data = lsu_data; end
      SRC_MDU: begin sel_rd = mdu_rd; sel_data = mdu_data; end
      default: begin sel_rd = alu_rd; sel_data = alu_data; end
    endcase
  end

  always_comb begin
    rd_ena_d   = gnt_vld && (sel_rd != X0_IDX);
    rd_index_d = rd_index_q;
    rd_data_d  = rd_data_q;
    if (gnt_vld) begin
      rd_index_d = sel_rd;
      rd_data_d  = sel_data;
    end
    starve_d = starve_q;
    if (mdu_ready)                starve_d = '0;
    else if (mdu_valid && !starve) starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ena_q   <= 1'b0;
      rd_index_q <= '0;
      rd_data_q  <= '0;
      starve_q   <= '0;
    end else begin
      rd_ena_q   <= rd_ena_d;
      rd_index_q <= rd_index_d;
      rd_data_q  <= rd_data_d;
      starve_q   <= starve_d;
    end
  end

  assign rd_ena   = rd_ena_q;
  assign rd_index = rd_index_q;
  assign rd_data  = rd_data_q;

  wb_scoreboard #(
    .NREG  (NREG),
    .IDX_W (IDX_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .wr_ena      (rd_ena_q),
    .wr_index    (rd_index_q),
    .rs1_index   (rs1_index),
    .rs2_index   (rs2_index),
`ifdef WB_BYPASS_EN
    .rs1_fwd_hit (rs1_fwd_hit),
    .rs2_fwd_hit (rs2_fwd_hit),
`endif
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );

`ifdef WB_BYPASS_EN
  assign rs1_fwd_data = rd_data_q;
  assign rs2_fwd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: per-cycle vector table plus hand-written starvation, same-edge and reset sequences.
module tb_wb_ctrl;

`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, mdu_valid, iss_valid;
  logic        alu_ready, lsu_ready, mdu_ready;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd, iss_rd, rs1_index, rs2_index;
  logic [63:0] alu_data, lsu_data, mdu_data;
  logic        rs1_busy, rs2_busy;
  logic        rd_ena;
  logic [4:0]  rd_index;
  logic [63:0] rd_data;
`ifdef WB_BYPASS_EN
  logic        rs1_fwd_hit, rs2_fwd_hit;
  logic [63:0] rs1_fwd_data, rs2_fwd_data;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .mdu_valid    (mdu_valid),
    .mdu_ready    (mdu_ready),
    .mdu_rd       (mdu_rd),
    .mdu_data     (mdu_data),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .rs1_index    (rs1_index),
    .rs2_index    (rs2_index),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
`ifdef WB_BYPASS_EN
    .rs1_fwd_hit  (rs1_fwd_hit),
    .rs2_fwd_hit  (rs2_fwd_hit),
    .rs1_fwd_data (rs1_fwd_data),
    .rs2_fwd_data (rs2_fwd_data),
`endif
    .rd_ena       (rd_ena),
    .rd_index     (rd_index),
    .rd_data      (rd_data)
  );

  typedef struct {
    logic        av;  logic [4:0] ard; logic [63:0] ad;
    logic        lv;  logic [4:0] lrd; logic [63:0] ld;
    logic        mv;  logic [4:0] mrd; logic [63:0] md;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  q1;  logic [4:0] q2;
    logic        e_ar, e_lr, e_mr, e_ena;
    logic [4:0]  e_idx; logic [63:0] e_data;
    logic        e_b1, e_b2;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [63:0] ad,
    input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
    input logic mv, input logic [4:0] mrd, input logic [63:0] md,
    input logic iv, input logic [4:0] ird,
    input logic [4:0] q1, input logic [4:0] q2,
    input logic e_ar, input logic e_lr, input logic e_mr, input logic e_ena,
    input logic [4:0] e_idx, input logic [63:0] e_data,
    input logic e_b1, input logic e_b2);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.iv = iv; v.ird = ird; v.q1 = q1; v.q2 = q2;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_mr = e_mr; v.e_ena = e_ena;
    v.e_idx = e_idx; v.e_data = e_data; v.e_b1 = e_b1; v.e_b2 = e_b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act !== exp_v) $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  task automatic chk_ready(input string name, input logic a, input logic l, input logic m);
    chk({name, ".alu_ready"}, alu_ready, a);
    chk({name, ".lsu_ready"}, lsu_ready, l);
    chk({name, ".mdu_ready"}, mdu_ready, m);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    rs1_index = 0; rs2_index = 0;

    // x7 written by LSU at vector 6: busy cleared only a cycle later unless bypassed
    vecs[0]  = mk(1,5,64'hDEAD, 0,0,0,      0,0,0,       0,0, 5,0, 1,0,0,0, 0,0,         0,0);
    vecs[1]  = mk(0,0,0,        0,0,0,      0,0,0,       0,0, 5,0, 0,0,0,1, 5,64'hDEAD,  0,0);
    vecs[2]  = mk(0,0,0,        0,0,0,      0,0,0,       0,0, 5,0, 0,0,0,0, 0,0,         0,0);
    vecs[3]  = mk(0,0,0,        1,3,64'h33, 0,0,0,       1,7, 7,3, 0,1,0,0, 0,0,         0,0);
    vecs[4]  = mk(0,0,0,        0,0,0,      0,0,0,       0,0, 7,7, 0,0,0,1, 3,64'h33,    1,1);
    vecs[5]  = mk(0,0,0,        1,7,64'h77, 0,0,0,       0,0, 7,0, 0,1,0,0, 0,0,         1,0);
    vecs[6]  = mk(0,0,0,        0,0,0,      0,0,0,       0,0, 7,0, 0,0,0,1, 7,64'h77,    !BYP,0);
    vecs[7]  = mk(0,0,0,        0,0,0,      0,0,0,       0,0, 7,0, 0,0,0,0, 0,0,         0,0);
    vecs[8]  = mk(1,1,64'h11,   1,2,64'h22, 0,0,0,       0,0, 1,2, 1,0,0,0, 0,0,         0,0);
    vecs[9]  = mk(0,0,0,        1,2,64'h22, 0,0,0,       0,0, 1,2, 0,1,0,1, 1,64'h11,    0,0);
    vecs[10] = mk(0,0,0,        0,0,0,      0,0,0,       0,0, 1,2, 0,0,0,1, 2,64'h22,    0,0);
    vecs[11] = mk(0,0,0,        0,0,0,      1,0,64'h1234,1,0, 0,0, 0,0,1,0, 0,0,         0,0);
    vecs[12] = mk(0,0,0,        0,0,0,      0,0,0,       0,0, 0,0, 0,0,0,0, 0,0,         0,0);

    @(posedge clk);
    tick();
    chk("reset.rd_ena", rd_ena, 0);
    chk("reset.rd_index", rd_index, 0);
    chk("reset.rd_data", rd_data, 0);
    chk("reset.rs1_busy", rs1_busy, 0);
    rst = 0;

    for (int i = 0; i < 13; i++) begin
      tick();
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
      lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
      mdu_valid = vecs[i].mv; mdu_rd = vecs[i].mrd; mdu_data = vecs[i].md;
      iss_valid = vecs[i].iv; iss_rd = vecs[i].ird;
      rs1_index = vecs[i].q1; rs2_index = vecs[i].q2;
      @(negedge clk);
      chk_ready($sformatf("vec%0d", i), vecs[i].e_ar, vecs[i].e_lr, vecs[i].e_mr);
      chk($sformatf("vec%0d.rd_ena", i), rd_ena, vecs[i].e_ena);
      if (vecs[i].e_ena) begin
        chk($sformatf("vec%0d.rd_index", i), rd_index, vecs[i].e_idx);
        chk($sformatf("vec%0d.rd_data", i), rd_data, vecs[i].e_data);
      end
      chk($sformatf("vec%0d.rs1_busy", i), rs1_busy, vecs[i].e_b1);
      chk($sformatf("vec%0d.rs2_busy", i), rs2_busy, vecs[i].e_b2);
`ifdef WB_BYPASS_EN
      if (i == 6) begin
        chk("vec6.rs1_fwd_hit", rs1_fwd_hit, 1);
        chk("vec6.rs1_fwd_data", rs1_fwd_data, 64'h77);
      end
`endif
    end

    // Counter holds while MDU idle: 2 losses, 3 idle cycles, then 2 more losses before MDU wins.
    for (int c = 0; c < 8; c++) begin
      tick();
      idle_inputs();
      alu_valid = 1; alu_rd = 4; alu_data = 64'h40 + c;
      mdu_valid = (c < 2) || (c >= 5); mdu_rd = 6; mdu_data = 64'h60;
      @(negedge clk);
      chk_ready($sformatf("hold%0d", c), c != 7, 0, c == 7);
    end

    // All three valid for 6 cycles: A,A,A,A,M,A; LSU never wins.
    for (int c = 0; c < 6; c++) begin
      tick();
      alu_valid = 1; alu_rd = 10; alu_data = 64'hA0 + c;
      lsu_valid = 1; lsu_rd = 11; lsu_data = 64'hB0;
      mdu_valid = 1; mdu_rd = 12; mdu_data = 64'hC0;
      @(negedge clk);
      chk_ready($sformatf("starve%0d", c), c != 4, 0, c == 4);
      if (c == 5) begin
        chk("starve.mdu_wb_index", rd_index, 12);
        chk("starve.mdu_wb_data", rd_data, 64'hC0);
      end
    end

    // Same-edge set and clear of x9: set wins.
    tick();
    idle_inputs();
    lsu_valid = 1; lsu_rd = 9; lsu_data = 64'h99;
    tick();
    idle_inputs();
    iss_valid = 1; iss_rd = 9; rs1_index = 9;
    @(negedge clk);
    chk("same_edge.rd_ena", rd_ena, 1);
    chk("same_edge.rd_index", rd_index, 9);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("same_edge.busy9", rs1_busy, 1);

    // Reset mid-operation: busy[3] set and an ALU write in flight.
    tick();
    idle_inputs();
    iss_valid = 1; iss_rd = 3; rs1_index = 3;
    alu_valid = 1; alu_rd = 8; alu_data = 64'h88;
    tick();
    idle_inputs();
    @(negedge clk);
    chk("pre_rst.busy3", rs1_busy, 1);
    tick();
    rst = 1;
    alu_valid = 1; alu_rd = 8; alu_data = 64'h89;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 64'h2;
    mdu_valid = 1; mdu_rd = 1; mdu_data = 64'h1;
    @(negedge clk);
    chk_ready("in_rst", 0, 0, 0);
    tick();
    rst = 0;
    idle_inputs();
    @(negedge clk);
    chk("post_rst.rd_ena", rd_ena, 0);
    chk("post_rst.rd_index", rd_index, 0);
    chk("post_rst.rd_data", rd_data, 0);
    chk("post_rst.busy3", rs1_busy, 0);
    chk("post_rst.busy9", (rs1_index == 3) ? 1'b0 : 1'b1, 0);
    rs2_index = 9;
    #1;
    chk("post_rst.busy9_q", rs2_busy, 0);

    tick();
    idle_inputs();
    alu_valid = 1; alu_rd = 5; alu_data = 64'h55;
    @(negedge clk);
    chk_ready("after_rst", 1, 0, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("after_rst.rd_ena", rd_ena, 1);
    chk("after_rst.rd_data", rd_data, 64'h55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Write-side controller for the integer register file; generates the regfile's rd_ena/rd_index/rd_data write port.
- Arbitrates three result sources (ALU, LSU, MDU) onto the single write port, one write per cycle, with valid/ready handshakes.
- Keeps a per-register busy scoreboard: set at issue of a long-latency op, cleared at writeback.
- Decode reads the scoreboard through rs1/rs2 query ports to stall on pending operands.

Parameters:
- XLEN, 64, data width; matches the regfile data bus.
- NREG, 32, number of architectural registers; index width is log2(NREG) = 5.
- STARVE_MAX, 4, consecutive lost MDU arbitrations before the MDU is granted top priority.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted
- alu_rd  in  5  ALU destination index
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  load result valid
- lsu_ready  out  1  load result accepted
- lsu_rd  in  5  load destination index
- lsu_data  in  XLEN  load result
- mdu_valid  in  1  mul/div result valid
- mdu_ready  out  1  mul/div result accepted
- mdu_rd  in  5  mul/div destination index
- mdu_data  in  XLEN  mul/div result
- iss_valid  in  1  long-latency (LSU/MDU) op issued this cycle
- iss_rd  in  5  destination of the issued op
- rs1_index  in  5  scoreboard query index 1
- rs2_index  in  5  scoreboard query index 2
- rs1_busy  out  1  rs1_index has a pending write
- rs2_busy  out  1  rs2_index has a pending write
- rd_ena  out  1  regfile write enable
- rd_index  out  5  regfile write index
- rd_data  out  XLEN  regfile write data

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset, rst.
- Reset values: rd_ena=0, rd_index=0, rd_data=0; all busy bits 0; starvation counter 0.
  - Ready outputs are combinational, but forced to 0 while rst=1.
  - Reset mid-operation discards any pending write and clears the scoreboard.
- Arbitration (combinational, per cycle):
  - Default priority ALU > LSU > MDU.
  - If the starvation counter equals STARVE_MAX, priority becomes MDU > ALU > LSU.
  - Exactly one granted source gets ready=1; the others get ready=0.
  - With no valid source, all readies are 0.
  - ready never depends on the output stage: the output register is always free.
- Handshake: a transfer occurs on valid && ready at a rising edge.
  - Sources hold valid, rd and data stable until accepted.
- Write stage, latency 1:
  - Transfer at edge T means rd_ena/rd_index/rd_data show the accepted values during cycle T+1.
  - The regfile captures them at edge T+1; the value is readable from cycle T+2.
  - rd_ena=0 in any cycle following no transfer.
- x0 writes: a transfer with rd=0 completes the handshake, but rd_ena stays 0 and no busy bit changes.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle mdu_valid=1 and mdu_ready=0.
  - Clears on an MDU transfer.
  - Holds when mdu_valid=0.
- Scoreboard (NREG-1 flops, x0 hardwired 0):
  - Set at the edge where iss_valid=1 and iss_rd!=0.
  - Cleared at the edge where rd_ena=1 and rd_index matches.
  - Set and clear to the same index at the same edge: set wins, because a new producer is in flight.
- rs*_busy = busy[rs*_index]; the query index 0 always returns 0.
- ALU results never touch the scoreboard; decode handles ALU hazards by forwarding.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs rs1_fwd_hit (1), rs2_fwd_hit (1), rs1_fwd_data (XLEN), rs2_fwd_data (XLEN).
  - While rd_ena=1 and rs*_index==rd_index!=0: fwd_hit=1, fwd_data=rd_data, and rs*_busy is forced 0 that cycle.
  - Decode can consume the operand one cycle early.
- Undefined:
  - The fwd ports are absent.
  - rs*_busy is reported strictly from the scoreboard flops.

Decomposition:
- Shared package / defines: XLEN bus width, register index width, x0 index constant, source-ID encoding (SRC_ALU=0, SRC_LSU=1, SRC_MDU=2).
- One natural sub-module: wb_scoreboard (busy flops, set/clear priority, two query ports, optional bypass masking).
- Arbiter, starvation counter and output register stay in wb_ctrl.

Test Plan:
- ALU only, alu_valid=1, alu_rd=5, alu_data=0xDEAD at edge T -> during T+1: rd_ena=1, rd_index=5, rd_data=0xDEAD; rd_ena=0 at T+2 if idle.
- ALU+LSU+MDU all valid for 6 cycles, STARVE_MAX=4 -> ALU granted 4 cycles, counter hits 4, then the 5th grant goes to MDU; the counter clears.
- iss_valid, iss_rd=7 -> rs1_busy=1 for rs1_index=7 from the next cycle; LSU writes x7 -> busy=0 from T+2 (T+1 with WB_BYPASS_EN, fwd_hit=1 and fwd_data=lsu_data).
- Same-edge iss_rd=9 and rd_ena with rd_index=9 -> busy[9] remains 1.
- MDU transfer with mdu_rd=0 and data 0x1234 -> mdu_ready=1, rd_ena stays 0, rs1_busy for index 0 is 0.
- Set busy[3], assert rst for 1 cycle with alu_valid=1 -> all readies 0, rd_ena=0 next cycle, busy[3]=0.
